// File: rtl/lzs_pkg.sv
// Shared LZS definitions: unpacker FSM states, default datapath widths and a clog2 helper.
package lzs_pkg;

    typedef enum logic [1:0] {
        UNPACK_FILL  = 2'd0,
        UNPACK_RUN   = 2'd1,
        UNPACK_DRAIN = 2'd2,
        UNPACK_DONE  = 2'd3
    } unpack_state_e;

    localparam int LZS_IN_WIDTH  = 64;
    localparam int LZS_OUT_WIDTH = 13;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lzs_bit_shifter.sv
// Combinational MSB-aligned buffer shifter: consume from the top, then OR a word in just below
// the surviving bits. Bits below the valid count must already be zero.
module lzs_bit_shifter #(
    parameter int IN_WIDTH = 64,
    parameter int CNT_W    = 8
) (
    input  logic [2*IN_WIDTH-1:0] i_buf,
    input  logic [CNT_W-1:0]      i_shamt,
    input  logic                  i_app_en,
    input  logic [IN_WIDTH-1:0]   i_word,
    input  logic [CNT_W-1:0]      i_app_pos,
    output logic [2*IN_WIDTH-1:0] o_buf
);
    logic [2*IN_WIDTH-1:0] w_cons;
    logic [2*IN_WIDTH-1:0] w_app;

    always_comb begin
        w_cons = i_buf << i_shamt;
        w_app  = {i_word, {IN_WIDTH{1'b0}}} >> i_app_pos;
        o_buf  = w_cons | (i_app_en ? w_app : '0);
    end

endmodule

// File: rtl/lzs_bit_unpack.sv
// LZS bit-stream unpacker: word FIFO in, OUT_WIDTH-bit peek window out, with drain and flush.
// Define LZS_UNPACK_BYTESWAP_EN to byte-reverse each source word before it is appended.
module lzs_bit_unpack
    import lzs_pkg::*;
#(
    parameter int IN_WIDTH       = LZS_IN_WIDTH,
    parameter int OUT_WIDTH      = LZS_OUT_WIDTH,
    parameter int NEED_STR_WIDTH = 4,
    parameter int CNT_W          = clog2(2*IN_WIDTH+1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      flush,
    input  logic                      src_empty,
    output logic                      m_src_getn,
    input  logic [IN_WIDTH-1:0]       fi,
    input  logic                      m_last,
    input  logic [NEED_STR_WIDTH-1:0] stream_width,
    input  logic                      stream_ack,
    output logic [OUT_WIDTH-1:0]      stream_data,
    output logic                      stream_valid,
    output logic [CNT_W-1:0]          bit_cnt,
    output logic                      done,
    output logic                      err
);
    localparam int BUF_W = 2*IN_WIDTH;
    localparam logic [CNT_W-1:0]          C_OUT  = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0]          C_IN   = CNT_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0]          C_ROOM = CNT_W'(BUF_W-IN_WIDTH);
    localparam logic [NEED_STR_WIDTH-1:0] C_MAXW = NEED_STR_WIDTH'(OUT_WIDTH);

    unpack_state_e       r_state, w_state_n;
    logic [BUF_W-1:0]    r_buf, w_buf_n;
    logic [CNT_W-1:0]    r_cnt, w_cnt_c, w_cnt_n, w_width, w_shamt;
    logic                r_rd_pend, r_drop, r_last_seen, r_err, r_valid;
    logic                w_ack, w_wide, w_cons, w_over, w_issue, w_load, w_last_n, w_valid_n;
    logic [IN_WIDTH-1:0] w_word;

`ifdef LZS_UNPACK_BYTESWAP_EN
    always_comb begin
        w_word = '0;
        for (int b = 0; b < IN_WIDTH/8; b++)
            w_word[IN_WIDTH-1-8*b -: 8] = fi[8*b +: 8];
    end
`else
    assign w_word = fi;
`endif

    // Consume happens before append, so read issue and append position use the post-consume count.
    always_comb begin
        w_ack    = ce & stream_ack & r_valid;
        w_wide   = w_ack & (stream_width > C_MAXW);
        w_cons   = w_ack & ~w_wide;
        w_width  = CNT_W'(stream_width);
        w_over   = w_cons & (w_width > r_cnt);
        w_shamt  = w_cons ? w_width : '0;
        w_cnt_c  = w_over ? '0 : r_cnt - w_shamt;
        w_issue  = ce & ~src_empty & ~r_rd_pend & ~r_last_seen &
                   (r_state != UNPACK_DONE) & (w_cnt_c <= C_ROOM);
        w_load   = ce & r_rd_pend & ~r_drop & ~flush;
        w_cnt_n  = w_load ? w_cnt_c + C_IN : w_cnt_c;
        w_last_n = r_last_seen | (w_load & m_last);
    end

    assign m_src_getn = ~w_issue;

    lzs_bit_shifter #(.IN_WIDTH(IN_WIDTH), .CNT_W(CNT_W)) u_shift (
        .i_buf     (r_buf),
        .i_shamt   (w_shamt),
        .i_app_en  (w_load),
        .i_word    (w_word),
        .i_app_pos (w_cnt_c),
        .o_buf     (w_buf_n)
    );

    always_comb begin
        w_state_n = r_state;
        w_valid_n = 1'b0;
        if (flush) begin
            w_state_n = UNPACK_FILL;
        end else begin
            case (r_state)
                UNPACK_DONE:  w_state_n = UNPACK_DONE;
                UNPACK_DRAIN: w_state_n = (w_cnt_n == '0) ? UNPACK_DONE : UNPACK_DRAIN;
                default: begin
                    if (w_last_n & ~w_issue)
                        w_state_n = UNPACK_DRAIN;
                    else
                        w_state_n = (w_cnt_n >= C_OUT) ? UNPACK_RUN : UNPACK_FILL;
                end
            endcase
            case (w_state_n)
                UNPACK_DRAIN: w_valid_n = (w_cnt_n != '0);
                UNPACK_DONE:  w_valid_n = 1'b0;
                default:      w_valid_n = (w_cnt_n >= C_OUT);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= UNPACK_FILL;
        else if (ce)
            r_state <= w_state_n;
    end

    // A read issued in a flush cycle still returns a word next cycle; r_drop discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_rd_pend   <= 1'b0;
            r_drop      <= 1'b0;
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
        end else if (ce) begin
            r_rd_pend <= w_issue;
            r_valid   <= w_valid_n;
            if (flush) begin
                r_buf       <= '0;
                r_cnt       <= '0;
                r_last_seen <= 1'b0;
                r_drop      <= w_issue;
            end else begin
                r_buf       <= w_buf_n;
                r_cnt       <= w_cnt_n;
                r_last_seen <= w_last_n;
                r_drop      <= 1'b0;
                if (w_wide | w_over)
                    r_err <= 1'b1;
            end
        end
    end

    assign stream_data  = r_buf[BUF_W-1 -: OUT_WIDTH];
    assign stream_valid = r_valid;
    assign bit_cnt      = r_cnt;
    assign done         = (r_state == UNPACK_DONE);
    assign err          = r_err;

endmodule

// File: tb/tb_lzs_bit_unpack.sv
// Self-checking bench for lzs_bit_unpack: directed table, hand corner sequences, and a
// randomized stream checked against a bit-queue reference model.
module tb_lzs_bit_unpack;
    localparam int IW = 64;
    localparam int OW = 13;
    localparam int SW = 4;
    localparam int CW = $clog2(2*IW+1);

    logic          clk = 1'b0;
    logic          rst, ce, flush, src_empty, m_src_getn, m_last, stream_ack;
    logic          stream_valid, done, err;
    logic [IW-1:0] fi;
    logic [SW-1:0] stream_width;
    logic [OW-1:0] stream_data;
    logic [CW-1:0] bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lzs_bit_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .flush        (flush),
        .src_empty    (src_empty),
        .m_src_getn   (m_src_getn),
        .fi           (fi),
        .m_last       (m_last),
        .stream_width (stream_width),
        .stream_ack   (stream_ack),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .bit_cnt      (bit_cnt),
        .done         (done),
        .err          (err)
    );

    typedef struct {
        bit         ce;
        logic [3:0] w;
        bit         v;
        int         cnt;
        logic [12:0] d;
        bit         dn;
        bit         er;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] swapw(input logic [IW-1:0] w);
`ifdef LZS_UNPACK_BYTESWAP_EN
        logic [IW-1:0] r;
        for (int b = 0; b < IW/8; b++) r[IW-1-8*b -: 8] = w[8*b +: 8];
        return r;
`else
        return w;
`endif
    endfunction

    function automatic logic [OW-1:0] top_bits(input logic [IW-1:0] w);
        logic [IW-1:0] s;
        s = swapw(w);
        return s[IW-1 -: OW];
    endfunction

    task automatic do_reset();
        rst = 1'b1; ce = 1'b1; flush = 1'b0; src_empty = 1'b1; m_last = 1'b0;
        stream_ack = 1'b0; stream_width = '0; fi = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts and ends at a falling edge; read cycle then load cycle.
    task automatic load_word(input string tag, input logic [IW-1:0] w, input bit last, input bit lat);
        src_empty = 1'b0;
        #1 chk({tag, "_issue"}, m_src_getn, 1'b0);
        @(negedge clk);
        src_empty = 1'b1; fi = w; m_last = last;
        if (lat) chk({tag, "_not_early"}, stream_valid, 1'b0);
        @(negedge clk);
    endtask

    task automatic ack(input logic [3:0] w);
        stream_ack = 1'b1; stream_width = w;
        @(negedge clk);
        stream_ack = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int nwords, input bit fixed9);
        bit            q[$];
        bit            mcons[$];
        bit            dcons[$];
        logic [IW-1:0] srcq[$];
        logic [IW-1:0] arriving, sw;
        logic [OW-1:0] exp, dsnap;
        bit            pend, issued, mvalid, filled;
        int            cyc, drops, bad;
        pend = 0; filled = 0; cyc = 0; drops = 0; bad = 0; arriving = '0;
        do_reset();
        for (int i = 0; i < nwords; i++) srcq.push_back({$urandom, $urandom});
        while ((srcq.size() > 0 || pend || q.size() >= OW) && cyc < 4000) begin
            mvalid = (q.size() >= OW);
            chk({tag, "_valid"}, stream_valid, mvalid);
            chk({tag, "_cnt"}, bit_cnt, q.size());
            if (mvalid) begin
                exp = '0;
                for (int k = 0; k < OW; k++) exp[OW-1-k] = q[k];
                chk({tag, "_data"}, stream_data, exp);
            end
            if (stream_valid) filled = 1;
            else if (filled && srcq.size() > 0) drops++;
            if (pend) fi = arriving;
            src_empty = (srcq.size() == 0) || (!fixed9 && $urandom_range(0, 3) == 0);
            if (fixed9) begin
                stream_ack = 1'b1; stream_width = 4'd9;
            end else begin
                stream_ack   = ($urandom_range(0, 3) != 0);
                stream_width = 4'($urandom_range(0, OW));
            end
            #1;
            issued = !m_src_getn;
            dsnap  = stream_data;
            chk({tag, "_getn_legal"}, issued & (src_empty | pend), 1'b0);
            @(posedge clk);
            if (stream_ack && mvalid)
                for (int k = 0; k < int'(stream_width); k++) begin
                    mcons.push_back(q.pop_front());
                    dcons.push_back(dsnap[OW-1-k]);
                end
            if (pend) begin
                sw = swapw(arriving);
                for (int k = IW-1; k >= 0; k--) q.push_back(sw[k]);
            end
            pend = issued && srcq.size() > 0;
            if (pend) arriving = srcq.pop_front();
            cyc++;
            @(negedge clk);
        end
        stream_ack = 1'b0;
        chk({tag, "_timeout"}, cyc < 4000, 1'b1);
        foreach (mcons[i]) if (mcons[i] !== dcons[i]) bad++;
        chk({tag, "_concat"}, bad, 0);
        if (fixed9) chk({tag, "_bubble"}, drops, 0);
    endtask

    initial begin
        vec_t tbl[9];
        logic [IW-1:0] w;

        do_reset();
        #1;
        chk("rst_getn", m_src_getn, 1'b1);
        chk("rst_valid", stream_valid, 1'b0);
        chk("rst_data", stream_data, 13'h0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);

`ifndef LZS_UNPACK_BYTESWAP_EN
        tbl[0] = '{1'b1, 4'd13, 1'b1, 51, 13'h1400, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd0,  1'b1, 51, 13'h1400, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'd13, 1'b1, 51, 13'h1400, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'd13, 1'b1, 38, 13'h0000, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 4'd13, 1'b1, 25, 13'h0000, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'd13, 1'b1, 12, 13'h0002, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'd14, 1'b1, 12, 13'h0002, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 4'd12, 1'b0, 0,  13'h0000, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 4'd5,  1'b0, 0,  13'h0000, 1'b1, 1'b1};

        load_word("first", 64'hA5A5_0000_0000_0001, 1'b1, 1'b1);
        chk("first_valid", stream_valid, 1'b1);
        chk("first_data", stream_data, 13'h14B4);
        chk("first_cnt", bit_cnt, 64);
        for (int i = 0; i < 9; i++) begin
            ce = tbl[i].ce; stream_ack = 1'b1; stream_width = tbl[i].w;
            @(negedge clk);
            stream_ack = 1'b0; ce = 1'b1;
            chk($sformatf("tbl%0d_valid", i), stream_valid, tbl[i].v);
            chk($sformatf("tbl%0d_cnt", i), bit_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_data", i), stream_data, tbl[i].d);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
        end
`endif

        // Over-consume in DRAIN: 64 -> 12 -> 3, then ack 5.
        do_reset();
        load_word("ovf", 64'hA5A5_0000_0000_0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) ack(4'd13);
        ack(4'd9);
        chk("ovf_cnt3", bit_cnt, 3);
        chk("ovf_pre_err", err, 1'b0);
        ack(4'd5);
        chk("ovf_err", err, 1'b1);
        chk("ovf_done", done, 1'b1);
        chk("ovf_cnt", bit_cnt, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_clr", done, 1'b0);
        chk("flush_err_sticky", err, 1'b1);

        // Flush in the same cycle a read is issued.
        do_reset();
        load_word("fl0", 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        chk("fl0_cnt", bit_cnt, 64);
        flush = 1'b1; src_empty = 1'b0;
        #1 chk("fl_issue", m_src_getn, 1'b0);
        @(negedge clk);
        flush = 1'b0; src_empty = 1'b1; fi = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("fl_cnt", bit_cnt, 0);
        chk("fl_valid", stream_valid, 1'b0);
        chk("fl_done", done, 1'b0);
        @(negedge clk);
        chk("fl_drop_cnt", bit_cnt, 0);
        w = 64'hF0E1_D2C3_B4A5_9687;
        load_word("fl1", w, 1'b0, 1'b0);
        chk("fl1_cnt", bit_cnt, 64);
        chk("fl1_data", stream_data, top_bits(w));
        rst = 1'b1;
        #1;
        chk("rst_mid_cnt", bit_cnt, 0);
        chk("rst_mid_valid", stream_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ce low holds an outstanding load until ce returns.
        do_reset();
        src_empty = 1'b0;
        #1;
        @(negedge clk);
        w = 64'h1357_9BDF_2468_ACE0;
        fi = w; src_empty = 1'b1; ce = 1'b0;
        @(negedge clk);
        chk("ce_hold_cnt", bit_cnt, 0);
        chk("ce_getn", m_src_getn, 1'b1);
        ce = 1'b1;
        @(negedge clk);
        chk("ce_load_cnt", bit_cnt, 64);
        chk("ce_load_data", stream_data, top_bits(w));

        do_reset();
        load_word("bswap", 64'h0807_0605_0403_0201, 1'b0, 1'b0);
`ifdef LZS_UNPACK_BYTESWAP_EN
        chk("bswap_data", stream_data, 13'h0020);
`else
        chk("bswap_data", stream_data, 13'h0100);
`endif

        run_stream("cont", 8, 1'b1);
        run_stream("rnd", 40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
